// File: rtl/icache_refill_if.sv
// Memory-side bus of the I-cache refill engine: one line read request channel plus an
// unthrottled response beat channel.
interface icache_refill_if #(
  parameter int unsigned BUS_WIDTH   = 64,
  parameter int unsigned PADDR_WIDTH = 34
);
  logic                   req_vld;
  logic [PADDR_WIDTH-1:0] req_paddr;
  logic                   req_rdy;
  logic                   rsp_vld;
  logic [BUS_WIDTH-1:0]   rsp_data;

  modport master (
    output req_vld,
    output req_paddr,
    input  req_rdy,
    input  rsp_vld,
    input  rsp_data
  );

  modport slave (
    input  req_vld,
    input  req_paddr,
    output req_rdy,
    output rsp_vld,
    output rsp_data
  );
endinterface

// File: rtl/icache_refill.sv
// I-cache line refill engine: one line-aligned read per miss, eight beats gathered into a
// line and handed to the cache top as a single-cycle fill pulse; flushes drop the fill.
module icache_refill #(
  parameter int unsigned BUS_WIDTH   = 64,
  parameter int unsigned LINE_WIDTH  = 512,
  parameter int unsigned PADDR_WIDTH = 34
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   fetch_vld_i,
  input  logic                   miss_vld_i,
  input  logic [PADDR_WIDTH-1:0] miss_paddr_i,
  icache_refill_if.master        mem_io,
  output logic                   fill_vld_o,
  output logic [LINE_WIDTH-1:0]  fill_data_o,
  output logic                   refill_busy_o
);

  localparam int unsigned Beats = LINE_WIDTH / BUS_WIDTH;
  localparam int unsigned CntW  = $clog2(Beats);
  localparam int unsigned OffW  = $clog2(LINE_WIDTH / 8);

  typedef enum logic [1:0] {StIdle, StReq, StCollect, StDone} state_e;

  state_e                 state_q;
  logic [PADDR_WIDTH-1:0] addr_q;
  logic [CntW-1:0]        cnt_q;
  logic                   drop_q;
  logic [LINE_WIDTH-1:0]  line_q;

  logic miss_take;
  logic last_beat;
  logic unused_paddr_lsb;

  assign miss_take        = fetch_vld_i & miss_vld_i & ~flush_i;
  assign last_beat        = (cnt_q == CntW'(Beats - 1));
  assign unused_paddr_lsb = ^miss_paddr_i[OffW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      line_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss_take) begin
            addr_q  <= {miss_paddr_i[PADDR_WIDTH-1:OffW], {OffW{1'b0}}};
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            state_q <= StReq;
          end
        end
        StReq: begin
          // A flush racing the handshake cannot cancel the read, so its beats are drained.
          if (mem_io.req_rdy) begin
            drop_q  <= flush_i;
            state_q <= StCollect;
          end else if (flush_i) begin
            state_q <= StIdle;
          end
        end
        StCollect: begin
          if (flush_i) begin
            drop_q <= 1'b1;
          end
          if (mem_io.rsp_vld) begin
            for (int unsigned k = 0; k < Beats; k++) begin
              if (cnt_q == CntW'(k)) begin
                line_q[k*BUS_WIDTH +: BUS_WIDTH] <= mem_io.rsp_data;
              end
            end
            cnt_q <= cnt_q + 1'b1;
            if (last_beat) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_io.req_vld   = (state_q == StReq);
  assign mem_io.req_paddr = addr_q;
  assign fill_vld_o       = (state_q == StDone) & ~drop_q & ~flush_i;
  assign fill_data_o      = line_q;
  assign refill_busy_o    = (state_q != StIdle);

endmodule
